// File: rtl/alu_issue_ctrl.sv
// Issue controller for a clocked MIPS ALU: decodes an ALUOp/funct request, drives the ALU,
// waits out its latency and returns the captured result with a zero flag and an error flag.
module alu_issue_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ALU_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_aluop,
    input  logic [5:0]        req_funct,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_res,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam int              CNT_W    = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LATENCY - 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             dec_legal;
    logic [3:0]       dec_op;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    always_comb begin
        dec_legal = 1'b1;
        dec_op    = OP_ADD;
        unique case (req_aluop)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                unique case (req_funct)
                    6'b100000: dec_op = OP_ADD;
                    6'b100010: dec_op = OP_SUB;
                    6'b100100: dec_op = OP_AND;
                    6'b100101: dec_op = OP_OR;
                    6'b101010: dec_op = OP_SLT;
                    default:   dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (req_valid) state_next = dec_legal ? S_ISSUE : S_DONE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (wait_cnt == '0) state_next = S_DONE;
            S_DONE:  if (rsp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign req_ready = (state == S_IDLE);

    // NOTE: sequential state uses non-blocking assignments only, and the reset is sampled on
    // the clock edge so an in-flight request is dropped cleanly in any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= OP_AND;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_next;
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (dec_legal) begin
                            alu_a  <= req_a;
                            alu_b  <= req_b;
                            alu_op <= dec_op;
                        end else begin
                            // Illegal requests bypass the ALU entirely; its inputs keep their values.
                            rsp_data  <= '0;
                            rsp_zero  <= 1'b0;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                        end
                    end
                end
                S_ISSUE: wait_cnt <= CNT_INIT;
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        rsp_data  <= alu_res;
                        rsp_zero  <= (alu_res == '0);
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_DONE: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: a latency-accurate ALU model and a spec-level
// reference model checking directed cases plus randomized transactions.
module tb_alu_issue_ctrl;

    localparam int DW  = 32;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_aluop = '0;
    logic [5:0]    req_funct = '0;
    logic [DW-1:0] req_a = '0;
    logic [DW-1:0] req_b = '0;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [3:0]    alu_op;
    logic [DW-1:0] alu_res;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          rsp_zero;
    logic          rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] exp_a  = '0;
    logic [DW-1:0] exp_b  = '0;
    logic [3:0]    exp_op = '0;

    logic [5:0] funct_tab [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h21, 6'h3F};

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DATA_W(DW), .ALU_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_aluop(req_aluop), .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    // Clocked ALU model: result visible LAT edges after its inputs settle.
    function automatic logic [DW-1:0] alu_eval(input logic [3:0] op, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
            default: return '0;
        endcase
    endfunction

    logic [DW-1:0] pipe [LAT];
    always_ff @(posedge clk) begin
        pipe[0] <= alu_eval(alu_op, alu_a, alu_b);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign alu_res = pipe[LAT-1];

    // Reference: what the request means in MIPS terms, independent of how the block sequences it.
    function automatic void ref_model(input logic [1:0] aluop, input logic [5:0] funct,
                                      input logic [DW-1:0] a, input logic [DW-1:0] b,
                                      output bit legal, output logic [3:0] op,
                                      output logic [DW-1:0] res);
        legal = 1'b1; op = 4'b0000; res = '0;
        if (aluop == 2'b00) begin op = 4'b0010; res = a + b; end
        else if (aluop == 2'b01) begin op = 4'b0110; res = a - b; end
        else if (aluop == 2'b10 && funct == 6'b100000) begin op = 4'b0010; res = a + b; end
        else if (aluop == 2'b10 && funct == 6'b100010) begin op = 4'b0110; res = a - b; end
        else if (aluop == 2'b10 && funct == 6'b100100) begin op = 4'b0000; res = a & b; end
        else if (aluop == 2'b10 && funct == 6'b100101) begin op = 4'b0001; res = a | b; end
        else if (aluop == 2'b10 && funct == 6'b101010) begin
            op = 4'b0111; res = ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
        end
        else legal = 1'b0;
    endfunction

    task automatic run_txn(input string name, input logic [1:0] aluop, input logic [5:0] funct,
                           input logic [DW-1:0] a, input logic [DW-1:0] b, input int hold);
        bit            legal;
        logic [3:0]    op;
        logic [DW-1:0] res;
        logic [DW-1:0] exp_data;
        int            cycles;
        ref_model(aluop, funct, a, b, legal, op, res);
        exp_data = legal ? res : '0;
        @(negedge clk);
        req_valid = 1'b1; req_aluop = aluop; req_funct = funct; req_a = a; req_b = b;
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s req_ready before accept: got %b want 1", name, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_funct = 6'($urandom);
        if (legal) begin exp_a = a; exp_b = b; exp_op = op; end
        cycles = 0;
        while (rsp_valid !== 1'b1 && cycles < LAT + 6) begin
            n_tests++;
            if (alu_a !== exp_a || alu_b !== exp_b || alu_op !== exp_op) begin
                n_fail++;
                $display("FAIL %s alu inputs cyc %0d: got %h/%h/%h want %h/%h/%h", name, cycles,
                         alu_a, alu_b, alu_op, exp_a, exp_b, exp_op);
            end
            rsp_ready = 1'($urandom);
            @(negedge clk);
            cycles++;
        end
        rsp_ready = 1'b0;
        n_tests++;
        if (cycles !== (legal ? LAT + 1 : 0)) begin
            n_fail++; $display("FAIL %s latency: got %0d edges want %0d", name, cycles,
                               legal ? LAT + 1 : 0);
        end
        n_tests++;
        if (rsp_data !== exp_data || rsp_zero !== (legal && exp_data == '0) || rsp_err !== !legal) begin
            n_fail++;
            $display("FAIL %s response: got data=%h zero=%b err=%b want data=%h zero=%b err=%b",
                     name, rsp_data, rsp_zero, rsp_err, exp_data, legal && exp_data == '0, !legal);
        end
        n_tests++;
        if (alu_op !== exp_op || alu_a !== exp_a || alu_b !== exp_b) begin
            n_fail++; $display("FAIL %s alu after rsp: got op %h want %h", name, alu_op, exp_op);
        end
        for (int d = 0; d < hold; d++) begin
            req_valid = 1'b1; req_aluop = 2'b00; req_a = ~a; req_b = 32'h55;
            @(negedge clk);
            n_tests++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_data !== exp_data || rsp_err !== !legal) begin
                n_fail++;
                $display("FAIL %s hold %0d: got valid=%b ready=%b data=%h want 1/0/%h", name, d,
                         rsp_valid, req_ready, rsp_data, exp_data);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_data !== exp_data ||
            alu_op !== exp_op || alu_a !== exp_a) begin
            n_fail++;
            $display("FAIL %s handshake: got valid=%b ready=%b data=%h op=%h want 0/1/%h/%h", name,
                     rsp_valid, req_ready, rsp_data, alu_op, exp_data, exp_op);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_zero !== 1'b0 ||
            rsp_err !== 1'b0 || alu_a !== '0 || alu_b !== '0 || alu_op !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset: got ready=%b valid=%b data=%h op=%h want 1/0/0/0",
                     req_ready, rsp_valid, rsp_data, alu_op);
        end
        rst = 1'b0;
        exp_a = '0; exp_b = '0; exp_op = '0;
    endtask

    task automatic test_directed();
        run_txn("add_5_7",   2'b10, 6'b100000, 32'd5, 32'd7, 0);
        run_txn("beq_sub",   2'b01, 6'b000000, 32'h1234, 32'h1234, 1);
        run_txn("slt_neg",   2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 0);
        run_txn("slt_swap",  2'b10, 6'b101010, 32'd1, 32'hFFFF_FFFF, 0);
        run_txn("and",       2'b10, 6'b100100, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
        run_txn("or",        2'b10, 6'b100101, 32'hF000_0000, 32'h0000_000F, 0);
        run_txn("illegal_f", 2'b10, 6'b000000, 32'd9, 32'd9, 0);
        run_txn("illegal_op",2'b11, 6'b100000, 32'd1, 32'd2, 2);
    endtask

    task automatic test_back_pressure();
        run_txn("hold5_add", 2'b00, 6'b111111, 32'h7FFF_FFFF, 32'd1, 5);
        run_txn("hold5_err", 2'b10, 6'b100001, 32'd3, 32'd4, 5);
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        req_valid = 1'b1; req_aluop = 2'b00; req_a = 32'd100; req_b = 32'd23;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b0 || alu_op !== 4'b0010 || alu_a !== 32'd100) begin
            n_fail++; $display("FAIL mid_wait pre-reset: got valid=%b op=%h a=%h want 0/2/64",
                               rsp_valid, alu_op, alu_a);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_a = '0; exp_b = '0; exp_op = '0;
        n_tests++;
        if (rsp_valid !== 1'b0 || alu_op !== 4'b0000 || alu_a !== '0 || alu_b !== '0 ||
            req_ready !== 1'b1 || rsp_data !== '0) begin
            n_fail++; $display("FAIL mid_wait reset: got valid=%b op=%h ready=%b want 0/0/1",
                               rsp_valid, alu_op, req_ready);
        end
        repeat (LAT + 2) begin
            @(negedge clk);
            n_tests++;
            if (rsp_valid !== 1'b0) begin
                n_fail++; $display("FAIL mid_wait dropped: got rsp_valid=%b want 0", rsp_valid);
            end
        end
        run_txn("after_rst", 2'b10, 6'b100010, 32'd50, 32'd8, 0);
    endtask

    task automatic test_random();
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_txn($sformatf("rand%0d", i), 2'($urandom_range(0, 3)),
                    funct_tab[$urandom_range(0, 7)], a, b, $urandom_range(0, 3));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_pressure();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
